// File: rtl/led_counter_sequencer.sv
// LED counter sequencer: synchronises and debounces the step and mode buttons, then
// advances the LED value by hand (MANUAL) or from a free-running tick (AUTO_UP / AUTO_DOWN).
module led_counter_sequencer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_CYCLES     = 12_500_000
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Button,
    input  logic             i_Mode_Button,
    output logic [WIDTH-1:0] o_LED,
    output logic [1:0]       o_Mode,
    output logic             o_Paused,
    output logic             o_Step
);

    localparam logic [1:0] MANUAL    = 2'b00;
    localparam logic [1:0] AUTO_UP   = 2'b01;
    localparam logic [1:0] AUTO_DOWN = 2'b10;

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    // Bit 0 is the step button, bit 1 the mode button.
    logic [1:0]    w_raw;
    logic [1:0]    r_meta;
    logic [1:0]    r_sync;
    logic [1:0]    r_deb;
    logic [1:0]    r_deb_d;
    logic [DW-1:0] r_db_cnt [2];
    logic [1:0]    w_press;
    logic          w_step_press;
    logic          w_mode_press;

    logic [WIDTH-1:0] r_led;
    logic [1:0]       r_mode;
    logic             r_paused;
    logic             r_step;
    logic [TW-1:0]    r_tick;
    logic [1:0]       w_next_mode;
    logic             w_wrap;

    assign w_raw = {i_Mode_Button, i_Button};

    // Two-flop synchronisers followed by a stability counter per button.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_meta   <= 2'b00;
            r_sync   <= 2'b00;
            r_deb    <= 2'b00;
            r_deb_d  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_meta  <= w_raw;
            r_sync  <= r_meta;
            r_deb_d <= r_deb;
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_cnt[i] <= '0;
                    r_deb[i]    <= r_sync[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign w_press      = r_deb & ~r_deb_d;
    assign w_step_press = w_press[0];
    assign w_mode_press = w_press[1];
    assign w_wrap       = !r_paused && (r_tick == TICK_LAST);

    // Mode rotation; the unused encoding falls back to MANUAL.
    always_comb begin
        w_next_mode = MANUAL;
        case (r_mode)
            MANUAL:  w_next_mode = AUTO_UP;
            AUTO_UP: w_next_mode = AUTO_DOWN;
            default: w_next_mode = MANUAL;
        endcase
    end

    // Sequencer: mode press beats step press, which beats the tick wrap.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_led    <= '0;
            r_mode   <= MANUAL;
            r_paused <= 1'b0;
            r_step   <= 1'b0;
            r_tick   <= '0;
        end else if (w_mode_press) begin
            r_mode   <= w_next_mode;
            r_paused <= 1'b0;
            r_tick   <= '0;
            r_step   <= 1'b0;
        end else begin
            case (r_mode)
                MANUAL: begin
                    r_tick <= '0;
                    if (w_step_press) begin
                        r_led  <= r_led + WIDTH'(1);
                        r_step <= 1'b1;
                    end else begin
                        r_step <= 1'b0;
                    end
                end
                AUTO_UP, AUTO_DOWN: begin
                    if (!r_paused) begin
                        r_tick <= w_wrap ? '0 : r_tick + TW'(1);
                    end
                    // A step press on the wrap cycle only toggles pause; the wrap is consumed.
                    if (w_step_press) begin
                        r_paused <= ~r_paused;
                        r_step   <= 1'b0;
                    end else if (w_wrap) begin
                        r_led  <= (r_mode == AUTO_UP) ? r_led + WIDTH'(1) : r_led - WIDTH'(1);
                        r_step <= 1'b1;
                    end else begin
                        r_step <= 1'b0;
                    end
                end
                default: begin
                    r_mode   <= MANUAL;
                    r_paused <= 1'b0;
                    r_tick   <= '0;
                    r_step   <= 1'b0;
                end
            endcase
        end
    end

    assign o_LED    = r_led;
    assign o_Mode   = r_mode;
    assign o_Paused = r_paused;
    assign o_Step   = r_step;

endmodule

// File: tb/tb_led_counter_sequencer.sv
// Directed bench for led_counter_sequencer with short debounce and tick periods.
module tb_led_counter_sequencer;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       mbtn;
    logic [7:0] led;
    logic [1:0] mode;
    logic       paused;
    logic       step;

    int total;
    int bad;
    int step_cnt;

    typedef struct {
        logic       b;
        logic       m;
        int         n;
        logic [7:0] led;
        logic [1:0] mode;
        logic       paused;
        int         steps;
    } vec_t;

    vec_t tbl [26];

    led_counter_sequencer #(
        .WIDTH(8),
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES(8)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Button(btn),
        .i_Mode_Button(mbtn),
        .o_LED(led),
        .o_Mode(mode),
        .o_Paused(paused),
        .o_Step(step)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
        if (step === 1'b1) step_cnt++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic is_mode);
        if (is_mode) mbtn = 1'b1; else btn = 1'b1;
        repeat (8) cyc();
        mbtn = 1'b0;
        btn  = 1'b0;
        repeat (7) cyc();
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; btn = 1'b0; mbtn = 1'b0;
        total = 0; bad = 0; step_cnt = 0;

        //        b     m     n    led    mode   p     steps
        tbl[0]  = '{1'b0, 1'b1, 8,   8'h10, 2'b01, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b0, 7,   8'h11, 2'b01, 1'b0, 1};
        tbl[2]  = '{1'b0, 1'b0, 8,   8'h12, 2'b01, 1'b0, 1};
        tbl[3]  = '{1'b1, 1'b0, 8,   8'h12, 2'b01, 1'b1, 0};
        tbl[4]  = '{1'b0, 1'b0, 7,   8'h12, 2'b01, 1'b1, 0};
        tbl[5]  = '{1'b0, 1'b0, 40,  8'h12, 2'b01, 1'b1, 0};
        tbl[6]  = '{1'b1, 1'b0, 8,   8'h13, 2'b01, 1'b0, 1};
        tbl[7]  = '{1'b0, 1'b0, 7,   8'h13, 2'b01, 1'b0, 0};
        tbl[8]  = '{1'b0, 1'b0, 1,   8'h14, 2'b01, 1'b0, 1};
        tbl[9]  = '{1'b0, 1'b1, 8,   8'h14, 2'b10, 1'b0, 0};
        tbl[10] = '{1'b0, 1'b0, 7,   8'h13, 2'b10, 1'b0, 1};
        tbl[11] = '{1'b0, 1'b1, 8,   8'h13, 2'b00, 1'b0, 0};
        tbl[12] = '{1'b0, 1'b0, 7,   8'h13, 2'b00, 1'b0, 0};
        tbl[13] = '{1'b1, 1'b1, 8,   8'h13, 2'b01, 1'b0, 0};
        tbl[14] = '{1'b0, 1'b0, 7,   8'h14, 2'b01, 1'b0, 1};
        tbl[15] = '{1'b0, 1'b0, 1,   8'h14, 2'b01, 1'b0, 0};
        tbl[16] = '{1'b1, 1'b0, 8,   8'h14, 2'b01, 1'b1, 0};
        tbl[17] = '{1'b0, 1'b0, 7,   8'h14, 2'b01, 1'b1, 0};
        tbl[18] = '{1'b0, 1'b1, 8,   8'h14, 2'b10, 1'b0, 0};
        tbl[19] = '{1'b0, 1'b0, 7,   8'h13, 2'b10, 1'b0, 1};
        tbl[20] = '{1'b0, 1'b0, 152, 8'h00, 2'b10, 1'b0, 19};
        tbl[21] = '{1'b0, 1'b0, 8,   8'hFF, 2'b10, 1'b0, 1};
        tbl[22] = '{1'b0, 1'b1, 8,   8'hFF, 2'b00, 1'b0, 0};
        tbl[23] = '{1'b0, 1'b0, 7,   8'hFF, 2'b00, 1'b0, 0};
        tbl[24] = '{1'b1, 1'b0, 8,   8'h00, 2'b00, 1'b0, 1};
        tbl[25] = '{1'b0, 1'b0, 7,   8'h00, 2'b00, 1'b0, 0};

        repeat (3) cyc();
        check("rst_led", led, 8'h00);
        check("rst_mode", mode, 2'b00);
        check("rst_paused", paused, 1'b0);
        check("rst_step", step, 1'b0);
        rst = 1'b0;
        repeat (2) cyc();

        // Short glitch must be filtered out.
        step_cnt = 0;
        btn = 1'b1;
        repeat (3) cyc();
        btn = 1'b0;
        repeat (6) cyc();
        check("glitch_led", led, 8'h00);
        check("glitch_steps", step_cnt, 0);

        // Held press: LED changes exactly seven edges after the raw rise.
        btn = 1'b1;
        repeat (6) cyc();
        check("lat_e6_led", led, 8'h00);
        check("lat_e6_step", step, 1'b0);
        cyc();
        check("lat_e7_led", led, 8'h01);
        check("lat_e7_step", step, 1'b1);
        cyc();
        check("lat_e8_step", step, 1'b0);
        repeat (2) cyc();
        btn = 1'b0;
        step_cnt = 0;
        repeat (8) cyc();
        check("release_led", led, 8'h01);
        check("release_steps", step_cnt, 0);

        for (int k = 0; k < 15; k++) press(1'b0);
        check("manual_0x10", led, 8'h10);

        for (int i = 0; i < 26; i++) begin
            btn  = tbl[i].b;
            mbtn = tbl[i].m;
            step_cnt = 0;
            repeat (tbl[i].n) cyc();
            check($sformatf("vec%0d_led", i), led, tbl[i].led);
            check($sformatf("vec%0d_mode", i), mode, tbl[i].mode);
            check($sformatf("vec%0d_paused", i), paused, tbl[i].paused);
            check($sformatf("vec%0d_steps", i), step_cnt, tbl[i].steps);
        end
        btn = 1'b0;
        mbtn = 1'b0;

        // Count up to 0x05 in AUTO_UP, then reset asynchronously between edges.
        press(1'b1);
        repeat (32) cyc();
        check("pre_rst_led", led, 8'h05);
        check("pre_rst_mode", mode, 2'b01);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_led", led, 8'h00);
        check("async_rst_mode", mode, 2'b00);
        check("async_rst_paused", paused, 1'b0);
        check("async_rst_step", step, 1'b0);

        // Button held through reset release registers as a single press.
        btn = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        step_cnt = 0;
        repeat (6) cyc();
        check("held_rst_e6_led", led, 8'h00);
        cyc();
        check("held_rst_e7_led", led, 8'h01);
        check("held_rst_e7_step", step, 1'b1);
        btn = 1'b0;
        repeat (8) cyc();
        check("held_rst_led", led, 8'h01);
        check("held_rst_steps", step_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
